// File: rtl/rv_pkg.sv
// Shared definitions for the RV execution units: operation encodings, FSM
// states, single-bit constants and small op-classification helpers.
package rv_pkg;

    localparam logic ZERO = 1'b0;
    localparam logic ONE  = 1'b1;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic op_is_rem(input muldiv_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic op_a_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 iteration on the packed {hi, lo} accumulator:
// restoring-divide subtract/shift when mode_div=1, shift-add multiply otherwise.
module muldiv_step
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              mode_div,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] diff;
    logic [XLEN:0] sum;

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    always_comb begin
        acc_o = acc_i;
        diff  = acc_i[2*XLEN-1:XLEN-1] - {ZERO, b_i};
        sum   = {ZERO, acc_i[2*XLEN-1:XLEN]} + {ZERO, b_i};
        if (mode_div) begin
            // Partial remainder is always < divisor, so a clear top bit means "fits".
            if (!diff[XLEN]) begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], ONE};
            end else begin
                acc_o = {acc_i[2*XLEN-2:0], ZERO};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[XLEN-1:1]};
            end else begin
                acc_o = {ZERO, acc_i[2*XLEN-1:1]};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit (IDLE -> CALC -> DONE).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; divides stay iterative.
module muldiv_unit
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  muldiv_op_e      op,
    input  logic [XLEN-1:0] oprnd_a,
    input  logic [XLEN-1:0] oprnd_b,
    input  logic            kill,
    output logic            ready,
    output logic            valid,
    output logic [XLEN-1:0] result
);

    localparam int              CW         = $clog2(XLEN);
    localparam logic [CW-1:0]   COUNT_INIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG   = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic [CW-1:0]     count_q, count_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              neg_q, neg_d;
    logic              spec_q, spec_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;

    logic              a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res;
    logic [2*XLEN-1:0] step_acc;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode_div (op_is_div(op_q)),
        .acc_i    (acc_q),
        .b_i      (b_q),
        .acc_o    (step_acc)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    // The core works on magnitudes; the sign is reapplied once the raw result is known.
    function automatic logic [XLEN-1:0] finalize(input muldiv_op_e o, input logic neg,
                                                 input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg ? -acc : acc;
        quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (o)
            OP_MUL:                       return prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              return quo;
            default:                      return rem;
        endcase
    endfunction

    always_comb begin
        a_neg    = op_a_signed(op) && oprnd_a[XLEN-1];
        b_neg    = op_b_signed(op) && oprnd_b[XLEN-1];
        a_mag    = a_neg ? -oprnd_a : oprnd_a;
        b_mag    = b_neg ? -oprnd_b : oprnd_b;
        div_zero = op_is_div(op) && (oprnd_b == '0);
        div_ovf  = (op == OP_DIV || op == OP_REM) && (oprnd_a == MOST_NEG) && (oprnd_b == '1);
        spec_res = '0;
        if (div_zero) begin
            spec_res = op_is_rem(op) ? oprnd_a : '1;
        end else if (div_ovf) begin
            spec_res = op_is_rem(op) ? '0 : oprnd_a;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        count_d  = count_q;
        acc_d    = acc_q;
        b_d      = b_q;
        result_d = result_q;
        neg_d    = neg_q;
        spec_d   = spec_q;
        valid_d  = ZERO;
        case (state_q)
            ST_IDLE: begin
                if (start && ready_q && !kill) begin
                    op_d    = op;
                    neg_d   = op_is_rem(op) ? a_neg : (a_neg ^ b_neg);
                    b_d     = b_mag;
                    acc_d   = {{XLEN{1'b0}}, a_mag};
                    count_d = COUNT_INIT;
                    spec_d  = ZERO;
                    state_d = ST_CALC;
                    if (div_zero || div_ovf) begin
                        spec_d  = ONE;
                        acc_d   = {{XLEN{1'b0}}, spec_res};
                        count_d = '0;
                        state_d = ST_DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op_is_div(op)) begin
                        acc_d   = fast_prod;
                        count_d = '0;
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_CALC: begin
                if (kill) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    if (count_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!kill) begin
                    valid_d  = ONE;
                    result_d = spec_q ? acc_q[XLEN-1:0] : finalize(op_q, neg_q, acc_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            count_q  <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
            neg_q    <= ZERO;
            spec_q   <= ZERO;
            ready_q  <= ONE;
            valid_q  <= ZERO;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            result_q <= result_d;
            neg_q    <= neg_d;
            spec_q   <= spec_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
        end
    end

    assign ready  = ready_q;
    assign valid  = valid_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// traffic scored against an arithmetic reference model.
module tb_muldiv_unit;
    import rv_pkg::*;

    localparam int XLEN = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             kill;
    muldiv_op_e       op;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             ready;
    logic             valid;
    logic [XLEN-1:0]  result;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] hold_res = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .oprnd_a (a),
        .oprnd_b (b),
        .kill    (kill),
        .ready   (ready),
        .valid   (valid),
        .result  (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the ISA arithmetic definitions.
    function automatic logic [31:0] model(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y);
        int          sx;
        int          sy;
        longint      sp;
        logic [63:0] up;
        sx = x;
        sy = y;
        case (o)
            OP_MUL:    begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
            OP_MULH:   begin sp = longint'(sx) * longint'(sy); return sp[63:32]; end
            OP_MULHSU: begin sp = longint'(sx) * longint'({32'b0, y}); return sp[63:32]; end
            OP_MULHU:  begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
            OP_DIV: begin
                if (y == 0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return x;
                return sx / sy;
            end
            OP_REM: begin
                if (y == 0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
                return sx % sy;
            end
            OP_DIVU: return (y == 0) ? 32'hFFFFFFFF : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_lat(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y);
        bit is_div;
        is_div = o inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        if (is_div && y == 0) return 1;
        if ((o == OP_DIV || o == OP_REM) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!is_div) return 1;
`endif
        return XLEN + 1;
    endfunction

    // Single compare process: every valid must match the oldest expectation,
    // and result must hold its last delivered value whenever valid is low.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result", result, e.res);
                    check("latency", cyc - e.acc_cyc, e.lat);
                    hold_res = e.res;
                end
            end else begin
                check("result_hold", result, hold_res);
            end
        end
    end

    // Caller sits at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input muldiv_op_e o, input logic [31:0] x, input logic [31:0] y, input bit track);
        int   n;
        exp_t e;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_wait_timeout", ready, 1);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (track) begin
            e.res     = model(o, x, y);
            e.acc_cyc = cyc;
            e.lat     = exp_lat(o, x, y);
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int acc;
        rst_n = 1'b0;
        start = 1'b0;
        kill  = 1'b0;
        op    = OP_MUL;
        a     = '0;
        b     = '0;

        // Model pinned against hand-computed values.
        check("model_div",    model(OP_DIV,    32'd7,        32'hFFFFFFFE), 32'hFFFFFFFD);
        check("model_rem",    model(OP_REM,    32'd7,        32'hFFFFFFFE), 32'h00000001);
        check("model_mulhsu", model(OP_MULHSU, 32'hFFFFFFFF, 32'h00000002), 32'hFFFFFFFF);
        check("model_mulh",   model(OP_MULH,   32'h80000000, 32'h80000000), 32'h40000000);

        repeat (3) @(negedge clk);
        check("rst_ready",  ready,  1);
        check("rst_valid",  valid,  0);
        check("rst_result", result, 0);

        // Start on the first edge after reset release.
        rst_n = 1'b1;
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1);
        wait_done("drain_div");
        check("div_7_m2", result, 32'hFFFFFFFD);
        issue(OP_REM, 32'd7, 32'hFFFFFFFE, 1);
        wait_done("drain_rem");
        check("rem_7_m2", result, 32'h00000001);

        issue(OP_DIVU, 32'd5, 32'd0, 1);
        wait_done("drain_divu0");
        check("divu_by0", result, 32'hFFFFFFFF);
        issue(OP_REMU, 32'd5, 32'd0, 1);
        wait_done("drain_remu0");
        check("remu_by0", result, 32'h00000005);

        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1);
        wait_done("drain_ovf_div");
        check("div_ovf", result, 32'h80000000);
        issue(OP_REM, 32'h80000000, 32'hFFFFFFFF, 1);
        wait_done("drain_ovf_rem");
        check("rem_ovf", result, 32'h00000000);

        issue(OP_MULH, 32'h80000000, 32'h80000000, 1);
        wait_done("drain_mulh");
        check("mulh_min", result, 32'h40000000);
        issue(OP_MULHSU, 32'hFFFFFFFF, 32'h2, 1);
        wait_done("drain_mulhsu");
        check("mulhsu", result, 32'hFFFFFFFF);
        issue(OP_MULHU, 32'hFFFFFFFF, 32'h2, 1);
        wait_done("drain_mulhu");
        check("mulhu", result, 32'h00000001);
        issue(OP_MUL, 32'hFFFFFFFF, 32'h2, 1);
        wait_done("drain_mul");
        check("mul_low", result, 32'hFFFFFFFE);

        // Kill together with start in IDLE: request must not be taken.
        @(negedge clk);
        op    = OP_DIVU;
        a     = 32'd1;
        b     = 32'd0;
        start = 1'b1;
        kill  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        check("kill_idle_ready", ready, 1);
        repeat (3) @(negedge clk);

        // Kill mid-CALC; a second start while busy must be ignored.
        issue(OP_DIVU, 32'd100, 32'd7, 0);
        acc = cyc;
        repeat (3) @(negedge clk);
        check("busy_ready", ready, 0);
        op    = OP_MUL;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < acc + 9) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill_ready",  ready,  1);
        check("kill_valid",  valid,  0);
        check("kill_result", result, 32'hFFFFFFFE);
        repeat (40) @(negedge clk);

        // Randomized traffic, mixing back-to-back issue with idle gaps.
        for (int i = 0; i < 250; i++) begin
            issue(muldiv_op_e'($urandom_range(0, 7)), pick(), pick(), 1);
            if ($urandom_range(0, 1) == 0) wait_done("drain_rand");
        end
        wait_done("drain_rand_final");

        // Asynchronous reset in the middle of a divide.
        issue(OP_MUL, 32'd6, 32'd7, 1);
        wait_done("drain_pre_reset");
        check("pre_reset_mul", result, 32'd42);
        issue(OP_DIV, 32'd1000, 32'd3, 1);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready",  ready,  1);
        check("async_rst_valid",  valid,  0);
        check("async_rst_result", result, 0);
        exp_q.delete();
        hold_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_REMU, 32'd1000, 32'd7, 1);
        wait_done("drain_post_reset");
        check("post_reset_remu", result, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request strobe, accepted only when ready=1.
REQ-005 SHALL have port op  input  muldiv_op_e (3)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-006 SHALL have ports oprnd_a and oprnd_b  input  XLEN  rs1 and rs2 values.
REQ-007 SHALL have port kill  input  1  pipeline flush, aborts any in-flight operation.
REQ-008 SHALL have port ready  output  1  high only in IDLE.
REQ-009 SHALL have port valid  output  1  one-cycle result strobe.
REQ-010 SHALL have port result  output  XLEN  result, held stable from valid until the next accepted start.

Function
REQ-011 SHALL implement FSM states IDLE, CALC and DONE.
REQ-012 SHALL, on start&&ready&&!kill in IDLE, latch op and operand magnitudes, record result sign, and go to CALC with count=XLEN-1; special cases go directly to DONE.
REQ-013 SHALL treat as special cases: divisor zero, giving DIV/DIVU = all-ones and REM/REMU = oprnd_a; and signed overflow (a = most-negative, b = -1), giving DIV = a and REM = 0.
REQ-014 SHALL, in CALC, perform one radix-2 step per cycle: restoring divide for DIV/DIVU/REM/REMU; shift-add on a 2*XLEN accumulator for multiplies; count decrements each cycle; at count==0, go to DONE.
REQ-015 SHALL treat operands by sign as follows: MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU unsigned; quotient sign is sign(a)^sign(b); remainder sign is sign(a).
REQ-016 SHALL select result as: MUL = product[XLEN-1:0]; MULH* = product[2*XLEN-1:XLEN]; DIV* = quotient; REM* = remainder.
REQ-017 SHALL, in DONE, drive valid=1 and ready=0 for exactly one cycle, then return to IDLE.
REQ-018 SHALL raise valid XLEN+1 edges after the accepting edge for iterative ops and 1 edge after for special cases.
REQ-019 SHALL ignore start when ready=0, with no queueing.
REQ-020 SHALL, on kill in CALC or DONE, go to IDLE on the next edge with valid=0 and result unchanged; kill with start in IDLE SHALL leave start unaccepted.
REQ-021 SHALL, for an op encoding outside muldiv_op_e, produce result=0 with special-case latency.

Reset
REQ-022 SHALL, on rst_n low at any time including mid-operation, immediately force state=IDLE, ready=1, valid=0, result=0, count=0 and accumulators=0.
REQ-023 SHALL accept a start on the first rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with MULDIV_FAST_MUL_EN defined, compute all four multiplies with a single-cycle XLEN x XLEN product; multiplies go IDLE->DONE with valid 1 edge after acceptance.
REQ-025 SHALL, with MULDIV_FAST_MUL_EN undefined, use the iterative multiply path per REQ-014 with latency XLEN+1; divide behaviour SHALL be identical in both builds.

Structure
REQ-026 SHALL take muldiv_op_e, the FSM state enum and ZERO/ONE constants from the shared rv_pkg package.
REQ-027 SHALL instantiate one sub-module, muldiv_step: a combinational single radix-2 step (divide subtract/restore or multiply add/shift), selected by a mode bit.

Verification
REQ-028 SHALL verify: DIV a=7, b=-2 (0xFFFFFFFE) -> result 0xFFFFFFFD; REM -> 0x00000001; valid exactly 33 edges after accept.
REQ-029 SHALL verify: DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 0x00000005; both with 1-edge latency.
REQ-030 SHALL verify: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0x00000000.
REQ-031 SHALL verify: MULH a=b=0x80000000 -> 0x40000000; MULHSU a=0xFFFFFFFF, b=0x00000002 -> 0xFFFFFFFF; MULHU same operands -> 0x00000001; MUL -> 0xFFFFFFFE.
REQ-032 SHALL verify: DIVU 100/7 started, kill pulsed at cycle 10 -> no valid, ready=1 the next cycle, result unchanged; a second start during CALC is ignored.
REQ-033 SHALL verify: rst_n asserted mid-CALC -> ready=1, valid=0, result=0 without waiting for a clock edge.
